dcache_wt: RTL

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline's memory stage and the external data memory bus.
- Read hits are serviced in the same cycle. Misses and all stores stall the pipeline through `stall_o` while a single-word bus transaction completes.
- Line size is one word; there are no byte enables (word accesses only).

---
 rtl/dcache_wt.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wt #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             stall_o,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);

  localparam int LINES = 2 ** IDX_BITS;
  localparam int TAG_W = WIDTH - IDX_BITS - 2;

  typedef enum logic [1:0] {IDLE, RFILL, WBUS, WDONE} state_t;

  state_t               state_q, state_d;
  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_arr  [LINES];
  logic [WIDTH-1:0]     data_arr [LINES];

  logic [IDX_BITS-1:0]  cpu_idx, fill_idx;
  logic [TAG_W-1:0]     cpu_tag, fill_tag;
  logic                 hit, rd_req, stall_raw;
  logic                 unused_addr_bits;

  assign cpu_idx  = cpu_addr[IDX_BITS+1:2];
  assign cpu_tag  = cpu_addr[WIDTH-1:IDX_BITS+2];
  // Refill target comes from the held bus address, not the CPU port.
  assign fill_idx = mem_addr[IDX_BITS+1:2];
  assign fill_tag = mem_addr[WIDTH-1:IDX_BITS+2];
  assign hit      = valid_q[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign rd_req   = cpu_re && !cpu_we;
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          stall_raw = 1'b1;
          state_d   = WBUS;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = data_arr[cpu_idx];
          end else begin
            stall_raw = 1'b1;
            state_d   = RFILL;
          end
        end
      end
      RFILL: begin
        stall_raw = 1'b1;
        if (mem_ack) state_d = IDLE;
      end
      WBUS: begin
        stall_raw = 1'b1;
        if (mem_ack) state_d = WDONE;
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall must drop immediately while reset is held, even before any edge.
  assign stall_o = stall_raw & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cpu_we) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {cpu_addr[WIDTH-1:2], 2'b00};
            mem_wdata <= cpu_wdata;
          end else if (cpu_re && !hit) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {cpu_addr[WIDTH-1:2], 2'b00};
          end
        end
        RFILL: begin
          if (mem_ack) begin
            mem_req           <= 1'b0;
            valid_q[fill_idx] <= 1'b1;
          end
        end
        WBUS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && cpu_we && hit)
      data_arr[cpu_idx] <= cpu_wdata;
    if (state_q == RFILL && mem_ack) begin
      data_arr[fill_idx] <= mem_rdata;
      tag_arr[fill_idx]  <= fill_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == IDLE && rd_req) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_rd_req;
  assign unused_rd_req = rd_req;
`endif

endmodule
